// File: rtl/game_flow_controller.sv
// Rhythm-game sequencer: reset/load/arm/countdown/play/pause/end flow that owns
// the song timebase (deltatime) and drives the downstream loader, scheduler and mixer.
module game_flow_controller #(
  parameter int                TIME_W   = 13,
  parameter logic [TIME_W-1:0] SONG_LEN = 13'h1FFF,
  parameter int                CD_TICKS = 4,
  parameter int                CD_W     = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Press_Start,
  input  logic              Press_Pause,
  input  logic              Tick,
  input  logic              Load_Done,
  output logic              Load_Req,
  output logic              Game_Reset,
  output logic              Game_Start,
  output logic              Game_Paused,
  output logic              Game_End,
  output logic [CD_W-1:0]   Countdown,
  output logic [TIME_W-1:0] deltatime,
  output logic [2:0]        State_Dbg
);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    LOAD  = 3'd1,
    READY = 3'd2,
    COUNT = 3'd3,
    PLAY  = 3'd4,
    PAUSE = 3'd5,
    END_S = 3'd6
  } state_t;

  localparam logic [TIME_W-1:0] SONG_LAST = SONG_LEN - TIME_W'(1);

  state_t            state, next;
  logic              start_prev, pause_prev;
  logic              start_press, pause_press;
  logic [CD_W-1:0]   cd;
  logic [TIME_W-1:0] dt;

  // Prev regs come out of reset high so a key held through reset never fires.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      start_prev <= 1'b1;
      pause_prev <= 1'b1;
    end else begin
      start_prev <= Press_Start;
      pause_prev <= Press_Pause;
    end
  end

  assign start_press = Press_Start & ~start_prev;
  assign pause_press = Press_Pause & ~pause_prev;

  always_comb begin
    next = state;
    case (state)
      INIT:  next = LOAD;
      LOAD:  if (Load_Done) next = READY;
      READY: if (start_press) next = COUNT;
      COUNT: if (Tick && cd == CD_W'(1)) next = PLAY;
      PLAY: begin
        // Song end takes priority over a pause press in the same cycle.
        if ((Tick && dt == SONG_LAST) || dt == SONG_LEN) next = END_S;
        else if (pause_press)                              next = PAUSE;
      end
      PAUSE: if (pause_press || start_press) next = PLAY;
      END_S: if (start_press) next = INIT;
      default: next = INIT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= INIT;
      cd    <= '0;
      dt    <= '0;
    end else begin
      state <= next;
      case (state)
        INIT:  begin cd <= '0; dt <= '0; end
        READY: if (start_press) cd <= CD_W'(CD_TICKS);
        COUNT: if (Tick && cd != '0) cd <= cd - CD_W'(1);
        PLAY:  if (Tick && dt < SONG_LEN) dt <= dt + TIME_W'(1);
        default: ;
      endcase
    end
  end

  assign Game_Reset  = (state == INIT);
  assign Load_Req    = (state == LOAD);
  assign Game_Start  = (state == PLAY);
  assign Game_Paused = (state == PAUSE);
  assign Game_End    = (state == END_S);
  assign Countdown   = cd;
  assign deltatime   = dt;
  assign State_Dbg   = state;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller built with an 8-tick song.
module tb_game_flow_controller;
  logic        Clk = 1'b0;
  logic        Reset, Press_Start, Press_Pause, Tick, Load_Done;
  logic        Load_Req, Game_Reset, Game_Start, Game_Paused, Game_End;
  logic [2:0]  Countdown;
  logic [12:0] deltatime;
  logic [2:0]  State_Dbg;
  int checks = 0;
  int errors = 0;

  game_flow_controller #(.TIME_W(13), .SONG_LEN(13'd8), .CD_TICKS(4), .CD_W(3)) dut (
    .Clk(Clk), .Reset(Reset), .Press_Start(Press_Start), .Press_Pause(Press_Pause),
    .Tick(Tick), .Load_Done(Load_Done), .Load_Req(Load_Req), .Game_Reset(Game_Reset),
    .Game_Start(Game_Start), .Game_Paused(Game_Paused), .Game_End(Game_End),
    .Countdown(Countdown), .deltatime(deltatime), .State_Dbg(State_Dbg)
  );

  always #5 Clk = ~Clk;

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1; Press_Start = 0; Press_Pause = 0; Tick = 0; Load_Done = 0;
    cyc(2);
    check("rst_state", State_Dbg, 0);
    check("rst_dt", deltatime, 0);
    check("rst_cd", Countdown, 0);

    Reset = 0;
    check("init_greset", Game_Reset, 1);
    cyc();
    check("load_greset_off", Game_Reset, 0);
    check("load_req", Load_Req, 1);
    check("load_state", State_Dbg, 1);
    cyc();
    check("load_wait", State_Dbg, 1);
    Load_Done = 1; cyc(); Load_Done = 0;
    check("ready_state", State_Dbg, 2);
    check("ready_loadreq", Load_Req, 0);

    Press_Pause = 1; cyc(); Press_Pause = 0;
    check("ready_pause_ign", State_Dbg, 2);
    cyc();

    Press_Start = 1; cyc(); Press_Start = 0;
    check("count_state", State_Dbg, 3);
    check("cd4", Countdown, 4);
    Tick = 1;
    cyc(); check("cd3", Countdown, 3);
    cyc(); check("cd2", Countdown, 2);
    cyc(); check("cd1", Countdown, 1);
    check("count_dt", deltatime, 0);
    cyc(); check("cd0", Countdown, 0);
    check("play_start", Game_Start, 1);
    check("play_dt0", deltatime, 0);

    cyc(3);
    check("play_dt3", deltatime, 3);
    Press_Pause = 1; cyc(); Press_Pause = 0;
    check("pause_state", State_Dbg, 5);
    check("pause_flag", Game_Paused, 1);
    check("pause_dt4", deltatime, 4);
    cyc(10);
    check("pause_frozen", deltatime, 4);
    check("pause_still", State_Dbg, 5);
    Tick = 0; Press_Pause = 1; cyc(); Press_Pause = 0;
    check("resume_play", State_Dbg, 4);

    Tick = 1;
    cyc(3);
    check("play_dt7", deltatime, 7);
    check("play_not_end", State_Dbg, 4);
    cyc();
    check("end_dt", deltatime, 8);
    check("end_flag", Game_End, 1);
    cyc(5);
    check("end_sat", deltatime, 8);
    check("end_hold", State_Dbg, 6);
    Tick = 0;

    Press_Start = 1; cyc();
    check("replay_init", State_Dbg, 0);
    check("replay_greset", Game_Reset, 1);
    cyc();
    check("replay_load", Load_Req, 1);
    check("replay_dt0", deltatime, 0);
    Load_Done = 1; cyc(); Load_Done = 0;
    cyc(2);
    check("held_no_count", State_Dbg, 2);
    Press_Start = 0; cyc();
    Press_Start = 1; cyc(); Press_Start = 0;
    check("repress_count", State_Dbg, 3);

    Tick = 1; cyc(4);
    check("g2_play", State_Dbg, 4);
    cyc(5);
    check("g2_dt5", deltatime, 5);
    Tick = 0; Press_Pause = 1; cyc(); Press_Pause = 0;
    check("g2_pause", State_Dbg, 5);
    Reset = 1; Press_Start = 1; cyc();
    check("rst_pause_state", State_Dbg, 0);
    check("rst_pause_dt", deltatime, 0);
    cyc();
    Reset = 0;
    check("rst2_greset", Game_Reset, 1);
    cyc();
    check("rst2_loadreq", Load_Req, 1);
    Load_Done = 1; cyc(); Load_Done = 0;
    cyc(2);
    check("rst_held_ready", State_Dbg, 2);
    Press_Start = 0; cyc();
    Press_Start = 1; cyc(); Press_Start = 0;
    check("rst_repress_count", State_Dbg, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
